axil_seg7_array: RTL

- AXI4-Lite slave that drives a parametrised bank of 7-segment displays from a memory-mapped register file.
- Each digit has its own register selecting hex-decode or raw-segment mode, with per-digit blank and blink controls.
- A global control register and a programmable blink prescaler complete the register file.
- Sits on the lightweight HPS-to-FPGA bridge and drives the board HEX outputs directly.

---
 rtl/axil_seg7_array.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/axil_seg7_array.sv
// AXI4-Lite register file driving a bank of active-low 7-segment displays.
// Each digit has its own register (hex or raw mode, blank, blink). A global
// enable register and a blink half-period register complete the map.
//
// Write FSM states:
//   state      | meaning
//   W_IDLE     | waiting for AW and/or W
//   W_GOT_ADDR | address latched, waiting for write data
//   W_GOT_DATA | data latched, waiting for write address
//   W_WRITE    | apply strobed data to the latched register
//   W_RESP     | BVALID held until BREADY
module axil_seg7_array #(
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_DIGITS  = 6,
    parameter int BLINK_WIDTH = 24
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]              AWPROT,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [31:0]             WDATA,
    input  logic [3:0]              WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]              ARPROT,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [31:0]             RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [7*NUM_DIGITS-1:0] oSEG
);

    localparam logic [2:0] W_IDLE     = 3'd0;
    localparam logic [2:0] W_GOT_ADDR = 3'd1;
    localparam logic [2:0] W_GOT_DATA = 3'd2;
    localparam logic [2:0] W_WRITE    = 3'd3;
    localparam logic [2:0] W_RESP     = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR  = ADDR_WIDTH'(32'h40);
    localparam logic [ADDR_WIDTH-1:0] BLINK_ADDR = ADDR_WIDTH'(32'h44);
    localparam logic [18:0]           DIGIT_MASK = 19'h77F0F;
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;

    logic [2:0]              wstate_q, wstate_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              wstrb_q;
    logic [1:0]              bresp_q;
    logic                    rvalid_q;
    logic [31:0]             rdata_q;
    logic [1:0]              rresp_q;
    logic [18:0]             digit_q [NUM_DIGITS];
    logic                    ctrl_q;
    logic [BLINK_WIDTH-1:0]  blink_q;
    logic [BLINK_WIDTH-1:0]  blink_cnt_q;
    logic                    blink_phase_q;
    logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
    logic [31:0]             rd_val, wr_old, wr_merged, strb_mask;
    logic                    wr_fire, blink_wr;
    logic                    unused_ok;

    function automatic logic addr_mapped(input logic [ADDR_WIDTH-1:0] a);
        logic digit_hit;
        digit_hit = (a[ADDR_WIDTH-1:6] == '0) && (a[1:0] == 2'b00) &&
                    ({1'b0, a[5:2]} < 5'(NUM_DIGITS));
        return digit_hit || (a == CTRL_ADDR) || (a == BLINK_ADDR);
    endfunction

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Register read views for the read address and the latched write address
    always_comb begin
        rd_val = '0;
        wr_old = '0;
        if (ARADDR == CTRL_ADDR)    rd_val = {31'b0, ctrl_q};
        if (ARADDR == BLINK_ADDR)   rd_val = 32'(blink_q);
        if (awaddr_q == CTRL_ADDR)  wr_old = {31'b0, ctrl_q};
        if (awaddr_q == BLINK_ADDR) wr_old = 32'(blink_q);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (ARADDR == ADDR_WIDTH'(4*i))   rd_val = {13'b0, digit_q[i]};
            if (awaddr_q == ADDR_WIDTH'(4*i)) wr_old = {13'b0, digit_q[i]};
        end
    end

    assign strb_mask = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
    assign wr_merged = (wr_old & ~strb_mask) | (wdata_q & strb_mask);
    assign wr_fire   = (wstate_q == W_WRITE) && addr_mapped(awaddr_q);
    assign blink_wr  = wr_fire && (awaddr_q == BLINK_ADDR);

    // Write channel next-state
    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_IDLE: begin
                if (AWVALID && WVALID) wstate_d = W_WRITE;
                else if (AWVALID)      wstate_d = W_GOT_ADDR;
                else if (WVALID)       wstate_d = W_GOT_DATA;
            end
            W_GOT_ADDR: if (WVALID)  wstate_d = W_WRITE;
            W_GOT_DATA: if (AWVALID) wstate_d = W_WRITE;
            W_WRITE:                 wstate_d = W_RESP;
            W_RESP:     if (BREADY)  wstate_d = W_IDLE;
            default:                 wstate_d = W_IDLE;
        endcase
    end

    // Write channel state, address/data capture and response code
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wstate_q <= W_IDLE;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= RESP_OKAY;
        end else begin
            wstate_q <= wstate_d;
            if (AWVALID && AWREADY) awaddr_q <= AWADDR;
            if (WVALID && WREADY) begin
                wdata_q <= WDATA;
                wstrb_q <= WSTRB;
            end
            if (wstate_q == W_WRITE)
                bresp_q <= addr_mapped(awaddr_q) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Register file update; reserved bits are dropped on write
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            ctrl_q  <= 1'b1;
            blink_q <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
        end else if (wr_fire) begin
            if (awaddr_q == CTRL_ADDR)  ctrl_q  <= wr_merged[0];
            if (awaddr_q == BLINK_ADDR) blink_q <= wr_merged[BLINK_WIDTH-1:0];
            for (int i = 0; i < NUM_DIGITS; i++)
                if (awaddr_q == ADDR_WIDTH'(4*i)) digit_q[i] <= wr_merged[18:0] & DIGIT_MASK;
        end
    end

    // Read channel: capture data at acceptance, hold until RREADY
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (!rvalid_q) begin
            if (ARVALID) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_val;
                rresp_q  <= addr_mapped(ARADDR) ? RESP_OKAY : RESP_SLVERR;
            end
        end else if (RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    // Blink half-period counter; a BLINK write restarts the pattern
    always_ff @(posedge ACLK) begin
        if (!ARESETn || blink_wr || (blink_q == '0)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == blink_q - BLINK_WIDTH'(1)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BLINK_WIDTH'(1);
        end
    end

    // Segment pattern per digit, priority: off > raw > hex
    always_comb begin
        seg_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!ctrl_q || digit_q[i][17] || (digit_q[i][18] && blink_phase_q))
                seg_d[7*i +: 7] = 7'h7F;
            else if (digit_q[i][16])
                seg_d[7*i +: 7] = ~digit_q[i][14:8];
            else
                seg_d[7*i +: 7] = hex7(digit_q[i][3:0]);
        end
    end

    // Registered segment outputs, showing "0" on every digit out of reset
    always_ff @(posedge ACLK) begin
        if (!ARESETn) seg_q <= {NUM_DIGITS{7'h40}};
        else          seg_q <= seg_d;
    end

    assign AWREADY   = (wstate_q == W_IDLE) || (wstate_q == W_GOT_DATA);
    assign WREADY    = (wstate_q == W_IDLE) || (wstate_q == W_GOT_ADDR);
    assign BVALID    = (wstate_q == W_RESP);
    assign BRESP     = bresp_q;
    assign ARREADY   = ~rvalid_q;
    assign RVALID    = rvalid_q;
    assign RDATA     = rdata_q;
    assign RRESP     = rresp_q;
    assign oSEG      = seg_q;
    assign unused_ok = ^{AWPROT, ARPROT, wr_merged};

endmodule
